// File: rtl/mips32_prog_loader.sv
// Byte-stream program loader: parses a counted, XOR-checksummed image and writes it into
// instruction memory while holding the MIPS32 core in reset until the image verifies.
module mips32_prog_loader #(
    parameter int ADDR_W       = 10,
    parameter int DEPTH        = 1024,
    parameter int CPU_RST_HOLD = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    input  logic              load_req,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_rst,
    output logic              load_done,
    output logic              load_err,
    output logic [ADDR_W:0]   words_loaded
);

    typedef enum logic [2:0] {
        S_HDR_HI,
        S_HDR_LO,
        S_DATA,
        S_CHECK,
        S_DONE,
        S_ERROR
    } state_t;

    localparam logic [15:0]       DEPTH_W   = 16'(DEPTH);
    localparam logic [3:0]        HOLD_W    = 4'(CPU_RST_HOLD);
    localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
    localparam logic [ADDR_W:0]   WORDS_ONE = (ADDR_W + 1)'(1);

    state_t            state_q;
    logic [7:0]        cnt_hi_q;
    logic [15:0]       cnt_q;
    logic [7:0]        acc_q;
    logic [1:0]        idx_q;
    logic [23:0]       shift_q;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic              cpu_rst_q;
    logic              done_q;
    logic              err_q;
    logic [ADDR_W:0]   words_q;
    logic [3:0]        hold_q;

    logic              xfer;
    logic [15:0]       hdr_n;
    logic              last_word;

    assign byte_ready = !rst && (state_q != S_DONE) && (state_q != S_ERROR);
    assign xfer       = byte_valid && byte_ready;
    assign hdr_n      = {cnt_hi_q, byte_data};
    // Earlier words are always committed by the time the 4th byte of the next word arrives.
    assign last_word  = (16'(words_q) + 16'd1) == cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_HDR_HI;
            cnt_hi_q  <= 8'd0;
            cnt_q     <= 16'd0;
            acc_q     <= 8'd0;
            idx_q     <= 2'd0;
            shift_q   <= 24'd0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= 32'd0;
            cpu_rst_q <= 1'b1;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            words_q   <= '0;
            hold_q    <= 4'd0;
        end else begin
            we_q <= 1'b0;
            if (we_q) begin
                addr_q  <= addr_q + ADDR_ONE;
                words_q <= words_q + WORDS_ONE;
            end
            case (state_q)
                S_HDR_HI: begin
                    if (xfer) begin
                        cnt_hi_q <= byte_data;
                        acc_q    <= acc_q ^ byte_data;
                        state_q  <= S_HDR_LO;
                    end
                end
                S_HDR_LO: begin
                    if (xfer) begin
                        cnt_q <= hdr_n;
                        acc_q <= acc_q ^ byte_data;
                        if (hdr_n == 16'd0) begin
                            state_q <= S_CHECK;
                        end else if (hdr_n > DEPTH_W) begin
                            state_q <= S_ERROR;
                            err_q   <= 1'b1;
                        end else begin
                            state_q <= S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    if (xfer) begin
                        acc_q <= acc_q ^ byte_data;
                        idx_q <= idx_q + 2'd1;
                        if (idx_q == 2'd3) begin
                            we_q    <= 1'b1;
                            wdata_q <= {shift_q, byte_data};
                            if (last_word) begin
                                state_q <= S_CHECK;
                            end
                        end else begin
                            shift_q <= {shift_q[15:0], byte_data};
                        end
                    end
                end
                S_CHECK: begin
                    if (xfer) begin
                        if (byte_data == acc_q) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                            hold_q  <= HOLD_W;
                        end else begin
                            state_q <= S_ERROR;
                            err_q   <= 1'b1;
                        end
                    end
                end
                S_DONE, S_ERROR: begin
                    if (load_req) begin
                        state_q   <= S_HDR_HI;
                        cpu_rst_q <= 1'b1;
                        done_q    <= 1'b0;
                        err_q     <= 1'b0;
                        addr_q    <= '0;
                        words_q   <= '0;
                        acc_q     <= 8'd0;
                        idx_q     <= 2'd0;
                        hold_q    <= 4'd0;
                    end else if (state_q == S_DONE && hold_q != 4'd0) begin
                        hold_q <= hold_q - 4'd1;
                        if (hold_q == 4'd1) begin
                            cpu_rst_q <= 1'b0;
                        end
                    end
                end
                default: state_q <= S_HDR_HI;
            endcase
        end
    end

    assign imem_we      = we_q;
    assign imem_addr    = addr_q;
    assign imem_wdata   = wdata_q;
    assign cpu_rst      = cpu_rst_q;
    assign load_done    = done_q;
    assign load_err     = err_q;
    assign words_loaded = words_q;

endmodule

// File: tb/tb_mips32_prog_loader.sv
// Bench for mips32_prog_loader: fixed vectors, timing sequences and random images checked
// against a stream-parsing reference model.
module tb_mips32_prog_loader;

    localparam int DEPTH = 1024;

    typedef struct {
        int          addr;
        logic [31:0] data;
    } wr_t;

    typedef struct {
        string        name;
        int           len;
        logic [127:0] bytes;
        logic         expDone;
        logic         expErr;
        int           expWords;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic        load_req;
    logic        imem_we;
    logic [9:0]  imem_addr;
    logic [31:0] imem_wdata;
    logic        cpu_rst;
    logic        load_done;
    logic        load_err;
    logic [10:0] words_loaded;

    int          nChecks = 0;
    int          nFails  = 0;

    logic [7:0]  streamQ[$];
    wr_t         expQ[$];
    wr_t         capQ[$];
    bit          expDone;
    bit          expErr;
    int          expWords;
    int          sendLen;
    vec_t        tbl[6];

    always #5 clk = ~clk;

    mips32_prog_loader #(.ADDR_W(10), .DEPTH(DEPTH), .CPU_RST_HOLD(2)) dut (
        .clk          (clk),
        .rst          (rst),
        .byte_valid   (byte_valid),
        .byte_data    (byte_data),
        .byte_ready   (byte_ready),
        .load_req     (load_req),
        .imem_we      (imem_we),
        .imem_addr    (imem_addr),
        .imem_wdata   (imem_wdata),
        .cpu_rst      (cpu_rst),
        .load_done    (load_done),
        .load_err     (load_err),
        .words_loaded (words_loaded)
    );

    always @(negedge clk) begin
        if (!rst && imem_we === 1'b1) begin
            capQ.push_back('{int'(imem_addr), imem_wdata});
        end
    end

    initial begin
        #600000;
        $display("[TB] FAIL global_timeout: simulation did not complete");
        $fatal(1, "[TB] timeout");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference: parse the stream by its format rules, independent of any state machine.
    task automatic modelLoad();
        int n;
        logic [7:0] x;
        expQ.delete();
        n = int'({streamQ[0], streamQ[1]});
        if (n > DEPTH) begin
            expErr = 1; expDone = 0; expWords = 0; sendLen = 2;
            return;
        end
        for (int i = 0; i < n; i++) begin
            expQ.push_back('{i, {streamQ[2+4*i], streamQ[3+4*i], streamQ[4+4*i], streamQ[5+4*i]}});
        end
        x = 8'd0;
        for (int i = 0; i < 2 + 4 * n; i++) x = x ^ streamQ[i];
        expDone  = (x == streamQ[2+4*n]);
        expErr   = !expDone;
        expWords = n;
        sendLen  = 2 + 4 * n + 1;
    endtask

    task automatic buildStream(input int n, input bit corrupt);
        logic [7:0] cs;
        logic [7:0] b;
        streamQ.delete();
        streamQ.push_back(n[15:8]);
        streamQ.push_back(n[7:0]);
        if (n <= DEPTH) begin
            cs = n[15:8] ^ n[7:0];
            for (int i = 0; i < 4 * n; i++) begin
                b = 8'($urandom_range(255, 0));
                streamQ.push_back(b);
                cs = cs ^ b;
            end
            if (corrupt) cs = cs ^ 8'($urandom_range(255, 1));
            streamQ.push_back(cs);
        end
    endtask

    task automatic doReset();
        rst = 1'b1; byte_valid = 1'b0; byte_data = 8'd0; load_req = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        capQ.delete();
    endtask

    task automatic sendByte(input logic [7:0] b, input int gapMax, input bit lreqRand);
        int gap;
        int tries;
        bit taken;
        gap = (gapMax > 0) ? int'($urandom_range(gapMax, 0)) : 0;
        repeat (gap) begin
            byte_valid = 1'b0;
            load_req = lreqRand ? 1'($urandom_range(1, 0)) : 1'b0;
            @(posedge clk);
            #1;
        end
        load_req   = lreqRand ? 1'($urandom_range(1, 0)) : 1'b0;
        byte_valid = 1'b1;
        byte_data  = b;
        tries = 0;
        taken = 0;
        while (!taken) begin
            @(negedge clk);
            if (byte_ready) taken = 1;
            @(posedge clk);
            #1;
            if (!taken) begin
                tries++;
                if (tries > 20) begin
                    checkOutput("byte_accept_timeout", 32'(tries), 32'd0);
                    break;
                end
            end
        end
        byte_valid = 1'b0;
        load_req   = 1'b0;
    endtask

    task automatic applyStimulus(input int gapMax, input bit lreqRand);
        modelLoad();
        capQ.delete();
        for (int i = 0; i < sendLen; i++) sendByte(streamQ[i], gapMax, lreqRand);
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic compareWrites(input string tag);
        int bad;
        bad = 0;
        checkOutput({tag, "_write_count"}, 32'(capQ.size()), 32'(expQ.size()));
        for (int i = 0; i < expQ.size() && i < capQ.size(); i++) begin
            if (capQ[i].addr != expQ[i].addr || capQ[i].data !== expQ[i].data) begin
                if (bad == 0)
                    $display("[TB] FAIL %s_write[%0d]: got %0h@%0d, expected %0h@%0d", tag, i,
                             capQ[i].data, capQ[i].addr, expQ[i].data, expQ[i].addr);
                bad++;
            end
        end
        checkOutput({tag, "_write_errors"}, 32'(bad), 32'd0);
    endtask

    task automatic checkModelResult(input string tag);
        checkOutput({tag, "_load_done"}, 32'(load_done), 32'(expDone));
        checkOutput({tag, "_load_err"}, 32'(load_err), 32'(expErr));
        checkOutput({tag, "_words_loaded"}, 32'(words_loaded), 32'(expWords));
        checkOutput({tag, "_cpu_rst"}, 32'(cpu_rst), 32'(!expDone));
        checkOutput({tag, "_byte_ready"}, 32'(byte_ready), 32'd0);
        compareWrites(tag);
    endtask

    task automatic restartViaReq(input string tag);
        load_req = 1'b1;
        @(posedge clk);
        #1;
        load_req = 1'b0;
        capQ.delete();
        checkOutput({tag, "_req_ready"}, 32'(byte_ready), 32'd1);
        checkOutput({tag, "_req_cpu_rst"}, 32'(cpu_rst), 32'd1);
        checkOutput({tag, "_req_flags"}, 32'({load_done, load_err}), 32'd0);
        checkOutput({tag, "_req_words"}, 32'(words_loaded), 32'd0);
        checkOutput({tag, "_req_addr"}, 32'(imem_addr), 32'd0);
    endtask

    task automatic loadT1();
        streamQ.delete();
        for (int i = 0; i < tbl[0].len; i++) streamQ.push_back(tbl[0].bytes[8*(tbl[0].len-1-i) +: 8]);
    endtask

    initial begin
        tbl[0] = '{"T1_load",    11, 128'h0002_2008_0005_0810_0000_37, 1'b1, 1'b0, 2};
        tbl[1] = '{"T2_badsum",  11, 128'h0002_2008_0005_0810_0000_36, 1'b0, 1'b1, 2};
        tbl[2] = '{"T3_empty",    3, 128'h0000_00,                     1'b1, 1'b0, 0};
        tbl[3] = '{"T4_oversize", 2, 128'h0401,                        1'b0, 1'b1, 0};
        tbl[4] = '{"one_word",    7, 128'h0001_DEAD_BEEF_23,           1'b1, 1'b0, 1};
        tbl[5] = '{"empty_bad",   3, 128'h0000_01,                     1'b0, 1'b1, 0};

        rst = 1'b1; byte_valid = 1'b0; byte_data = 8'd0; load_req = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_byte_ready", 32'(byte_ready), 32'd0);
        checkOutput("rst_cpu_rst", 32'(cpu_rst), 32'd1);
        checkOutput("rst_imem_we", 32'(imem_we), 32'd0);
        checkOutput("rst_imem_addr", 32'(imem_addr), 32'd0);
        checkOutput("rst_imem_wdata", imem_wdata, 32'd0);
        checkOutput("rst_flags", 32'({load_done, load_err}), 32'd0);
        checkOutput("rst_words", 32'(words_loaded), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        checkOutput("post_rst_ready", 32'(byte_ready), 32'd1);

        for (int v = 0; v < 6; v++) begin
            doReset();
            streamQ.delete();
            for (int i = 0; i < tbl[v].len; i++) streamQ.push_back(tbl[v].bytes[8*(tbl[v].len-1-i) +: 8]);
            applyStimulus(0, 1'b0);
            checkOutput({tbl[v].name, "_tbl_done"}, 32'(load_done), 32'(tbl[v].expDone));
            checkOutput({tbl[v].name, "_tbl_err"}, 32'(load_err), 32'(tbl[v].expErr));
            checkOutput({tbl[v].name, "_tbl_words"}, 32'(words_loaded), 32'(tbl[v].expWords));
            checkModelResult(tbl[v].name);
        end

        // T1 cycle timing: write strobe one cycle after 4th data byte, cpu_rst release delay.
        doReset();
        loadT1();
        modelLoad();
        for (int i = 0; i < 6; i++) sendByte(streamQ[i], 0, 1'b0);
        checkOutput("t1_we_pulse", 32'(imem_we), 32'd1);
        checkOutput("t1_we_addr", 32'(imem_addr), 32'd0);
        checkOutput("t1_we_data", imem_wdata, 32'h20080005);
        @(posedge clk);
        #1;
        checkOutput("t1_we_single", 32'(imem_we), 32'd0);
        checkOutput("t1_words_after_write", 32'(words_loaded), 32'd1);
        for (int i = 6; i < 10; i++) sendByte(streamQ[i], 0, 1'b0);
        sendByte(streamQ[10], 0, 1'b0);
        checkOutput("t1_done_at_accept", 32'(load_done), 32'd1);
        checkOutput("t1_cpu_rst_hold0", 32'(cpu_rst), 32'd1);
        @(posedge clk);
        #1;
        checkOutput("t1_cpu_rst_hold1", 32'(cpu_rst), 32'd1);
        @(posedge clk);
        #1;
        checkOutput("t1_cpu_rst_release", 32'(cpu_rst), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        checkModelResult("t1_timed");

        // Restart from DONE, then T1 with gaps and random load_req while loading.
        restartViaReq("done");
        loadT1();
        applyStimulus(5, 1'b1);
        checkModelResult("t5_gaps");

        // Reset mid-load after the 6th byte, then a full clean load.
        restartViaReq("pre_midrst");
        loadT1();
        for (int i = 0; i < 6; i++) sendByte(streamQ[i], 0, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("midrst_ready_forced", 32'(byte_ready), 32'd0);
        @(posedge clk);
        #1;
        checkOutput("midrst_we", 32'(imem_we), 32'd0);
        checkOutput("midrst_words", 32'(words_loaded), 32'd0);
        checkOutput("midrst_addr", 32'(imem_addr), 32'd0);
        checkOutput("midrst_cpu_rst", 32'(cpu_rst), 32'd1);
        rst = 1'b0;
        capQ.delete();
        applyStimulus(0, 1'b0);
        checkModelResult("midrst_reload");

        // Random images, restarting through load_req or reset.
        for (int r = 0; r < 12; r++) begin
            if (r % 2 == 0) restartViaReq($sformatf("rnd%0d", r));
            else doReset();
            buildStream(int'($urandom_range(12, 0)), 1'($urandom_range(1, 0)));
            applyStimulus(5, 1'b1);
            checkModelResult($sformatf("rnd%0d", r));
        end

        for (int r = 0; r < 3; r++) begin
            doReset();
            buildStream(int'($urandom_range(65535, DEPTH + 1)), 1'b0);
            applyStimulus(2, 1'b0);
            checkModelResult($sformatf("oversize%0d", r));
        end

        // Capacity boundary: exactly DEPTH words, last write at DEPTH-1.
        doReset();
        buildStream(DEPTH, 1'b0);
        applyStimulus(0, 1'b0);
        checkModelResult("full_depth");
        if (capQ.size() > 0)
            checkOutput("full_depth_last_addr", 32'(capQ[capQ.size()-1].addr), 32'(DEPTH - 1));

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
